split: RTL and testbench

SPLIT -- requirements
Module: split

---
 rtl/split_pkg.sv | 20 ++
 rtl/split_timer.sv | 29 ++
 rtl/split.sv | 145 ++++++++++++++
 tb/tb_split.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared encodings for the split address router: FSM states, target port and operation.
package split_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic {
      TGT_P0 = 1'b0,
      TGT_P1 = 1'b1
   } target_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

endpackage

// File: rtl/split_timer.sv
// BUSY-cycle watchdog for split; only instantiated when SPLIT_TIMEOUT_EN is defined.
module split_timer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Count value k is held during the (k+1)-th BUSY cycle, so TIMEOUT-1 marks the last one.
   assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/split.sv
// Routes one upstream transfer to port 0 (addr < OFFSET) or port 1 (addr >= OFFSET, rebased).
// Optional BUSY watchdog with err output is enabled by defining SPLIT_TIMEOUT_EN.
module split
   import split_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned WORD_WIDTH = 64,
   parameter int unsigned OFFSET     = 128,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [WORD_WIDTH-1:0] din,
   input  logic [WORD_WIDTH-1:0] dout,
   input  logic                  re,
   input  logic                  we,
   output logic                  ready,
   output logic [ADDR_WIDTH-1:0] maddr0,
   output logic [ADDR_WIDTH-1:0] maddr1,
   output logic [WORD_WIDTH-1:0] mout0,
   output logic [WORD_WIDTH-1:0] mout1,
   input  logic [WORD_WIDTH-1:0] min0,
   input  logic [WORD_WIDTH-1:0] min1,
   output logic                  mre0,
   output logic                  mre1,
   output logic                  mwe0,
   output logic                  mwe1,
   input  logic                  mready0,
   input  logic                  mready1
`ifdef SPLIT_TIMEOUT_EN
   ,
   output logic                  err
`endif
);

   localparam logic [ADDR_WIDTH-1:0] OFFSET_A = ADDR_WIDTH'(OFFSET);

   state_e  state_q;
   op_e     op_q;
   target_e tgt_q;

   logic                  req;
   logic                  req_tgt1;
   logic                  tgt_ready;
   logic [WORD_WIDTH-1:0] tgt_rdata;
   logic                  expired;

   assign req       = re | we;
   assign req_tgt1  = (addr >= OFFSET_A);
   assign tgt_ready = (tgt_q == TGT_P1) ? mready1 : mready0;
   assign tgt_rdata = (tgt_q == TGT_P1) ? min1 : min0;

`ifdef SPLIT_TIMEOUT_EN
   split_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     ((state_q == ST_IDLE) && req),
      .en_i      (state_q == ST_BUSY),
      .expired_o (expired)
   );
`else
   // TIMEOUT only matters with the watchdog; tie it off so the default build stays lint-quiet.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign expired        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_READ;
         tgt_q   <= TGT_P0;
         din     <= '0;
         ready   <= 1'b0;
         maddr0  <= '0;
         maddr1  <= '0;
         mout0   <= '0;
         mout1   <= '0;
         mre0    <= 1'b0;
         mre1    <= 1'b0;
         mwe0    <= 1'b0;
         mwe1    <= 1'b0;
`ifdef SPLIT_TIMEOUT_EN
         err     <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               ready <= 1'b0;
`ifdef SPLIT_TIMEOUT_EN
               err   <= 1'b0;
`endif
               // Write wins when both requests are high.
               if (req) begin
                  op_q    <= we ? OP_WRITE : OP_READ;
                  tgt_q   <= req_tgt1 ? TGT_P1 : TGT_P0;
                  maddr0  <= req_tgt1 ? '0 : addr;
                  maddr1  <= req_tgt1 ? (addr - OFFSET_A) : '0;
                  mout0   <= req_tgt1 ? '0 : dout;
                  mout1   <= req_tgt1 ? dout : '0;
                  mre0    <= !we && !req_tgt1;
                  mwe0    <=  we && !req_tgt1;
                  mre1    <= !we &&  req_tgt1;
                  mwe1    <=  we &&  req_tgt1;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (tgt_ready) begin
                  if (op_q == OP_READ) din <= tgt_rdata;
                  mre0    <= 1'b0;
                  mre1    <= 1'b0;
                  mwe0    <= 1'b0;
                  mwe1    <= 1'b0;
                  ready   <= 1'b1;
                  state_q <= ST_DONE;
               end else if (expired) begin
                  din     <= '1;
                  mre0    <= 1'b0;
                  mre1    <= 1'b0;
                  mwe0    <= 1'b0;
                  mwe1    <= 1'b0;
                  ready   <= 1'b1;
`ifdef SPLIT_TIMEOUT_EN
                  err     <= 1'b1;
`endif
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               ready   <= 1'b0;
`ifdef SPLIT_TIMEOUT_EN
               err     <= 1'b0;
`endif
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_split.sv
// Directed bench for split: routing, boundaries, priority, mready filtering, async reset, optional timeout.
module tb_split;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] addr;
   logic [63:0] din;
   logic [63:0] dout;
   logic        re;
   logic        we;
   logic        ready;
   logic [63:0] maddr0;
   logic [63:0] maddr1;
   logic [63:0] mout0;
   logic [63:0] mout1;
   logic [63:0] min0;
   logic [63:0] min1;
   logic        mre0;
   logic        mre1;
   logic        mwe0;
   logic        mwe1;
   logic        mready0;
   logic        mready1;
`ifdef SPLIT_TIMEOUT_EN
   logic        err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   split #(
      .ADDR_WIDTH (64),
      .WORD_WIDTH (64),
      .OFFSET     (128),
      .TIMEOUT    (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .din     (din),
      .dout    (dout),
      .re      (re),
      .we      (we),
      .ready   (ready),
      .maddr0  (maddr0),
      .maddr1  (maddr1),
      .mout0   (mout0),
      .mout1   (mout1),
      .min0    (min0),
      .min1    (min1),
      .mre0    (mre0),
      .mre1    (mre1),
      .mwe0    (mwe0),
      .mwe1    (mwe1),
      .mready0 (mready0),
      .mready1 (mready1)
`ifdef SPLIT_TIMEOUT_EN
      ,
      .err     (err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; addr = '0; dout = '0; re = 1'b0; we = 1'b0;
      min0 = '0; min1 = '0; mready0 = 1'b0; mready1 = 1'b0;

      #3;
      chk("rst_ready", ready, 0);
      chk("rst_mre0", mre0, 0);
      chk("rst_mwe1", mwe1, 0);
      chk("rst_din", din, 0);
      chk("rst_maddr1", maddr1, 0);
      tick();
      tick();
      rst = 1'b1;

      // Read at 5, target answers in the first BUSY cycle.
      addr = 64'd5; re = 1'b1; min0 = 64'hAA; mready0 = 1'b1;
      tick();
      re = 1'b0;
      chk("t1_mre0", mre0, 1);
      chk("t1_maddr0", maddr0, 5);
      chk("t1_mre1", mre1, 0);
      chk("t1_ready_busy", ready, 0);
      tick();
      chk("t1_ready", ready, 1);
      chk("t1_din", din, 64'hAA);
      chk("t1_mre0_off", mre0, 0);
      chk("t1_mre1_off", mre1, 0);
      mready0 = 1'b0;
      tick();
      chk("t1_ready_drop", ready, 0);

      // Write at 200 to port 1, mready1 arrives on the 4th BUSY cycle.
      addr = 64'd200; dout = 64'h55; we = 1'b1;
      tick();
      we = 1'b0;
      chk("t2_maddr1", maddr1, 72);
      chk("t2_mout1", mout1, 64'h55);
      chk("t2_mwe1_c1", mwe1, 1);
      chk("t2_mwe0", mwe0, 0);
      tick();
      chk("t2_mwe1_c2", mwe1, 1);
      tick();
      chk("t2_mwe1_c3", mwe1, 1);
      tick();
      chk("t2_mwe1_c4", mwe1, 1);
      chk("t2_no_ready", ready, 0);
      mready1 = 1'b1;
      tick();
      chk("t2_ready", ready, 1);
      chk("t2_mwe1_off", mwe1, 0);
      chk("t2_din_kept", din, 64'hAA);
      mready1 = 1'b0;
      tick();
      chk("t2_ready_drop", ready, 0);

      // Boundary: 127 stays on port 0.
      addr = 64'd127; re = 1'b1; mready0 = 1'b1; min0 = 64'h11;
      tick();
      re = 1'b0;
      chk("t3_maddr0_127", maddr0, 127);
      chk("t3_mre0_127", mre0, 1);
      chk("t3_mre1_127", mre1, 0);
      tick();
      chk("t3_din_127", din, 64'h11);
      mready0 = 1'b0;
      tick();

      // Boundary: 128 is port 1 address 0.
      addr = 64'd128; re = 1'b1; mready1 = 1'b1; min1 = 64'h22;
      tick();
      re = 1'b0;
      chk("t3_maddr1_128", maddr1, 0);
      chk("t3_mre1_128", mre1, 1);
      chk("t3_mre0_128", mre0, 0);
      tick();
      chk("t3_din_128", din, 64'h22);
      mready1 = 1'b0;
      tick();

      // re and we together: write only.
      addr = 64'd10; re = 1'b1; we = 1'b1; dout = 64'h77; mready0 = 1'b1; min0 = 64'h99;
      tick();
      re = 1'b0; we = 1'b0;
      chk("t3_prio_mwe0", mwe0, 1);
      chk("t3_prio_mre0", mre0, 0);
      chk("t3_prio_mout0", mout0, 64'h77);
      tick();
      chk("t3_prio_ready", ready, 1);
      chk("t3_prio_din", din, 64'h22);
      mready0 = 1'b0;
      tick();

      // Non-target mready is ignored.
      addr = 64'd300; re = 1'b1; mready0 = 1'b1; min1 = 64'h33;
      tick();
      re = 1'b0;
      chk("t4_mre1", mre1, 1);
      tick();
      chk("t4_no_ready1", ready, 0);
      chk("t4_mre1_hold", mre1, 1);
      tick();
      chk("t4_no_ready2", ready, 0);
      mready1 = 1'b1;
      tick();
      chk("t4_ready", ready, 1);
      chk("t4_din", din, 64'h33);
      mready1 = 1'b0;
      tick();

      // mready in IDLE without a request does nothing.
      mready0 = 1'b1; mready1 = 1'b1;
      tick();
      chk("t4_idle_ready1", ready, 0);
      tick();
      chk("t4_idle_ready2", ready, 0);
      chk("t4_idle_mre0", mre0, 0);
      mready0 = 1'b0; mready1 = 1'b0;

      // Reset mid-BUSY drops strobes without a clock edge.
      addr = 64'd20; re = 1'b1;
      tick();
      re = 1'b0;
      chk("t5_mre0_busy", mre0, 1);
      #2 rst = 1'b0;
      #1;
      chk("t5_mre0_async", mre0, 0);
      chk("t5_maddr0_async", maddr0, 0);
      tick();
      chk("t5_no_ready", ready, 0);
      rst = 1'b1;
      addr = 64'd40; re = 1'b1; mready0 = 1'b1; min0 = 64'h44;
      tick();
      re = 1'b0;
      chk("t5_after_mre0", mre0, 1);
      chk("t5_after_maddr0", maddr0, 40);
      tick();
      chk("t5_after_ready", ready, 1);
      chk("t5_after_din", din, 64'h44);
      mready0 = 1'b0;
      tick();

`ifdef SPLIT_TIMEOUT_EN
      // No completion: watchdog aborts after 8 BUSY cycles.
      addr = 64'd6; re = 1'b1;
      tick();
      re = 1'b0;
      chk("t6_mre0_c1", mre0, 1);
      chk("t6_err_busy", err, 0);
      for (int i = 2; i <= 8; i++) begin
         tick();
         chk("t6_mre0_hold", mre0, 1);
      end
      tick();
      chk("t6_mre0_off", mre0, 0);
      chk("t6_ready", ready, 1);
      chk("t6_err", err, 1);
      chk("t6_din", din, {64{1'b1}});
      tick();
      chk("t6_ready_drop", ready, 0);
      chk("t6_err_drop", err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
